// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer for the 9-bit CPU: owns PC/IR, steps
// FETCH/EXEC/MEM/WB, qualifies decoder strobes and counts retired instructions.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | out of reset, waiting for start
// S_FETCH | latch instruction from ROM, detect HALT
// S_EXEC  | decoder/ALU work on ir, route memory ops to S_MEM
// S_MEM   | data-memory request outstanding, timeout timer running
// S_WB    | register write strobe, PC update, retire count
// S_DONE  | halted normally, waiting for start
// S_FAULT | memory timeout, pc/ir hold faulting instruction
module cpu_sequencer #(
    parameter int PC_W        = 10,
    parameter int IW          = 9,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PC_W-1:0]  start_addr,
    input  logic [IW-1:0]    instr,
    input  logic             reg_write,
    input  logic             branch,
    input  logic             mem_write,
    input  logic             mem_to_reg,
    input  logic             taken,
    input  logic [PC_W-1:0]  target,
    input  logic             mem_ack,
    output logic [PC_W-1:0]  pc,
    output logic [IW-1:0]    ir,
    output logic             reg_wr_en,
    output logic             mem_req,
    output logic             mem_we,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [IW-1:0]     HALT_OP   = '1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_WB,
        S_DONE,
        S_FAULT
    } state_t;

    state_t state_q, state_d;

    logic [PC_W-1:0]   pc_q;
    logic [IW-1:0]     ir_q;
    logic [CNT_W-1:0]  retire_q;
    logic [WAIT_W-1:0] wait_q;
    logic              wait_tc;

    // Down-counter reaching zero marks the last MEM cycle allowed without an ack.
    assign wait_tc = (wait_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        reg_wr_en = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        fault     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                busy    = 1'b1;
                state_d = (instr == HALT_OP) ? S_DONE : S_EXEC;
            end
            S_EXEC: begin
                busy    = 1'b1;
                state_d = (mem_write || mem_to_reg) ? S_MEM : S_WB;
            end
            S_MEM: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                mem_we  = mem_write;
                if (mem_ack) begin
                    state_d = S_WB;
                end else if (wait_tc) begin
                    state_d = S_FAULT;
                end
            end
            S_WB: begin
                busy      = 1'b1;
                reg_wr_en = reg_write & ~branch & ~mem_write;
                state_d   = S_FETCH;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_d = S_FETCH;
            end
            S_FAULT: begin
                done  = 1'b1;
                fault = 1'b1;
                if (start) state_d = S_FETCH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= '0;
            ir_q     <= '0;
            retire_q <= '0;
            wait_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_FAULT: begin
                    if (start) begin
                        pc_q     <= start_addr;
                        retire_q <= '0;
                    end
                end
                S_FETCH: begin
                    ir_q <= instr;
                end
                S_EXEC: begin
                    wait_q <= WAIT_LOAD;
                end
                S_MEM: begin
                    if (!mem_ack && !wait_tc) wait_q <= wait_q - WAIT_W'(1);
                end
                S_WB: begin
                    pc_q <= (branch && taken) ? target : pc_q + PC_W'(1);
                    if (retire_q != '1) retire_q <= retire_q + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign pc         = pc_q;
    assign ir         = ir_q;
    assign retire_cnt = retire_q;

endmodule
